// File: rtl/coffee_pkg.sv
// coffee_pkg: controller state, coin code and coin value table shared by the credit controller.
package coffee_pkg;
    typedef enum logic [1:0] {IDLE, ADD, CHECK} state_t;
    typedef logic [1:0] coin_t;
    localparam logic [7:0] COIN_VALUE [4] = '{8'd1, 8'd2, 8'd5, 8'd10};
endpackage

// File: rtl/coffee_credit_ctrl_adder.sv
// coffee_credit_ctrl_adder: unsigned adder whose cin also selects subtraction (a + ~b + 1).
module coffee_credit_ctrl_adder #(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  cin,
    output logic [DATA_WIDTH-1:0] s,
    output logic                  cout
);
    logic [DATA_WIDTH-1:0] b_eff;
    assign b_eff = cin ? ~b : b;
    assign {cout, s} = {1'b0, a} + {1'b0, b_eff} + (DATA_WIDTH+1)'(cin);
endmodule

// File: rtl/coffee_credit_ctrl.sv
// coffee_credit_ctrl: credit register and payment sequencer sharing one adder for coin adds and price checks.
module coffee_credit_ctrl
    import coffee_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  coin_valid,
    input  coin_t                 coin_type,
    input  logic                  sel_valid,
    input  logic [DATA_WIDTH-1:0] price,
    input  logic                  cancel,
    output logic                  busy,
    output logic [DATA_WIDTH-1:0] credit,
    output logic                  dispense,
    output logic                  change_valid,
    output logic [DATA_WIDTH-1:0] change,
    output logic                  insufficient,
    output logic                  coin_reject
);
    state_t                state;
    logic [DATA_WIDTH-1:0] operand;
    logic [DATA_WIDTH-1:0] sum;
    logic                  cout;

    // In CHECK the adder computes credit - price; cout=1 means credit >= price.
    coffee_credit_ctrl_adder #(.DATA_WIDTH(DATA_WIDTH)) u_adder (
        .a   (credit),
        .b   (operand),
        .cin (state == CHECK),
        .s   (sum),
        .cout(cout)
    );

    assign busy = state != IDLE;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            credit       <= '0;
            change       <= '0;
            operand      <= '0;
            dispense     <= 1'b0;
            change_valid <= 1'b0;
            insufficient <= 1'b0;
            coin_reject  <= 1'b0;
        end else begin
            dispense     <= 1'b0;
            change_valid <= 1'b0;
            insufficient <= 1'b0;
            coin_reject  <= 1'b0;
            case (state)
                IDLE: begin
                    if (cancel) begin
                        change       <= credit;
                        credit       <= '0;
                        change_valid <= 1'b1;
                    end else if (sel_valid) begin
                        operand <= price;
                        state   <= CHECK;
                    end else if (coin_valid) begin
                        operand <= DATA_WIDTH'(COIN_VALUE[coin_type]);
                        state   <= ADD;
                    end
                end
                ADD: begin
                    if (cout) coin_reject <= 1'b1;
                    else credit <= sum;
                    state <= IDLE;
                end
                CHECK: begin
                    if (cout) begin
                        change       <= sum;
                        credit       <= '0;
                        dispense     <= 1'b1;
                        change_valid <= 1'b1;
                    end else begin
                        insufficient <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_coffee_credit_ctrl.sv
// tb_coffee_credit_ctrl: randomized and directed checks of the credit controller against a money-level model.
module tb_coffee_credit_ctrl;
    logic       clk = 0;
    logic       rst = 1;
    logic       coin_valid = 0;
    logic [1:0] coin_type = 0;
    logic       sel_valid = 0;
    logic [7:0] price = 0;
    logic       cancel = 0;
    logic       busy;
    logic [7:0] credit;
    logic       dispense;
    logic       change_valid;
    logic [7:0] change;
    logic       insufficient;
    logic       coin_reject;

    int checks = 0;
    int passed = 0;
    int m_credit = 0;
    int m_change = 0;
    int coin_val [4] = '{1, 2, 5, 10};

    coffee_credit_ctrl #(.DATA_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .coin_valid(coin_valid), .coin_type(coin_type),
        .sel_valid(sel_valid), .price(price), .cancel(cancel), .busy(busy),
        .credit(credit), .dispense(dispense), .change_valid(change_valid),
        .change(change), .insufficient(insufficient), .coin_reject(coin_reject)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one set of request inputs for a single cycle and checks the outcome the model predicts.
    task automatic request(input bit c, input bit s, input bit v, input int p, input int code, input string tag);
        bit two = 0, edisp = 0, ecv = 0, eins = 0, erej = 0;
        cancel = c; sel_valid = s; coin_valid = v; price = p[7:0]; coin_type = code[1:0];
        tick();
        cancel = 0; sel_valid = 0; coin_valid = 0;
        if (c) begin
            m_change = m_credit; m_credit = 0; ecv = 1;
        end else if (s) begin
            two = 1;
            if (m_credit >= p) begin m_change = m_credit - p; m_credit = 0; edisp = 1; ecv = 1; end
            else eins = 1;
        end else if (v) begin
            two = 1;
            if (m_credit + coin_val[code] > 255) erej = 1;
            else m_credit += coin_val[code];
        end
        if (two) begin
            checks++; if (busy !== 1'b1) $display("FAIL %s busy_mid: got %b want 1", tag, busy); else passed++;
            tick();
        end
        checks++; if (credit !== 8'(m_credit)) $display("FAIL %s credit: got %0d want %0d", tag, credit, m_credit); else passed++;
        checks++; if (change !== 8'(m_change)) $display("FAIL %s change: got %0d want %0d", tag, change, m_change); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL %s busy: got %b want 0", tag, busy); else passed++;
        checks++; if (dispense !== edisp) $display("FAIL %s dispense: got %b want %b", tag, dispense, edisp); else passed++;
        checks++; if (change_valid !== ecv) $display("FAIL %s change_valid: got %b want %b", tag, change_valid, ecv); else passed++;
        checks++; if (insufficient !== eins) $display("FAIL %s insufficient: got %b want %b", tag, insufficient, eins); else passed++;
        checks++; if (coin_reject !== erej) $display("FAIL %s coin_reject: got %b want %b", tag, coin_reject, erej); else passed++;
    endtask

    task automatic do_reset();
        rst = 1; tick(); tick(); rst = 0;
        m_credit = 0; m_change = 0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (credit !== 8'd0) $display("FAIL reset credit: got %0d want 0", credit); else passed++;
        checks++; if (change !== 8'd0) $display("FAIL reset change: got %0d want 0", change); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL reset busy: got %b want 0", busy); else passed++;
        checks++; if ({dispense, change_valid, insufficient, coin_reject} !== 4'b0)
            $display("FAIL reset pulses: got %b want 0000", {dispense, change_valid, insufficient, coin_reject}); else passed++;
    endtask

    task automatic test_coins_and_sale();
        request(0, 0, 1, 0, 2, "coin5");
        tick();
        request(0, 0, 1, 0, 2, "coin10");
        tick();
        request(0, 0, 1, 0, 1, "coin12");
        tick();
        request(0, 1, 0, 10, 0, "sale10");
        checks++; if (change !== 8'd2) $display("FAIL sale10 change_abs: got %0d want 2", change); else passed++;
    endtask

    task automatic test_insufficient();
        request(0, 0, 1, 0, 2, "ins_coin");
        request(0, 1, 0, 8, 0, "ins_sel");
        tick();
        checks++; if (insufficient !== 1'b0) $display("FAIL ins_width: got %b want 0", insufficient); else passed++;
        checks++; if (credit !== 8'd5) $display("FAIL ins_credit_abs: got %0d want 5", credit); else passed++;
    endtask

    task automatic test_reject();
        do_reset();
        for (int i = 0; i < 25; i++) request(0, 0, 1, 0, 3, "fill");
        request(0, 0, 1, 0, 3, "reject");
        checks++; if (credit !== 8'd250) $display("FAIL reject_abs: got %0d want 250", credit); else passed++;
        request(0, 0, 1, 0, 0, "after_reject");
        checks++; if (credit !== 8'd251) $display("FAIL after_reject_abs: got %0d want 251", credit); else passed++;
    endtask

    task automatic test_priority();
        do_reset();
        request(0, 0, 1, 0, 2, "pri_coin5");
        request(0, 0, 1, 0, 1, "pri_coin7");
        request(1, 1, 1, 3, 3, "pri_all");
        checks++; if (change !== 8'd7) $display("FAIL pri_change_abs: got %0d want 7", change); else passed++;
        tick();
        checks++; if (credit !== 8'd0 || busy !== 1'b0) $display("FAIL pri_after: credit %0d busy %b want 0 0", credit, busy); else passed++;
        request(0, 1, 1, 0, 3, "sel_over_coin");
    endtask

    task automatic test_reset_mid();
        bit seen = 0;
        do_reset();
        request(0, 0, 1, 0, 3, "mid_coin10");
        request(0, 0, 1, 0, 1, "mid_coin12");
        sel_valid = 1; price = 8'd3;
        tick();
        sel_valid = 0; rst = 1;
        tick();
        rst = 0; m_credit = 0; m_change = 0;
        checks++; if (credit !== 8'd0 || change !== 8'd0 || busy !== 1'b0)
            $display("FAIL mid_reset: credit %0d change %0d busy %b want 0 0 0", credit, change, busy); else passed++;
        for (int i = 0; i < 3; i++) begin
            seen |= dispense | change_valid;
            tick();
        end
        checks++; if (seen) $display("FAIL mid_reset_pulse: got 1 want 0"); else passed++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        request(0, 0, 1, 0, 3, "b2b_coin10");
        sel_valid = 1; price = 8'd10;
        tick();
        sel_valid = 0; cancel = 1; coin_valid = 1; coin_type = 2'd3;
        tick();
        cancel = 0; coin_valid = 0;
        checks++; if (dispense !== 1'b1 || change !== 8'd0 || credit !== 8'd0)
            $display("FAIL b2b_exact: disp %b change %0d credit %0d want 1 0 0", dispense, change, credit); else passed++;
        tick();
        checks++; if (credit !== 8'd0 || change_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL b2b_ignored: credit %0d cv %b busy %b want 0 0 0", credit, change_valid, busy); else passed++;
        m_credit = 0; m_change = 0;
        request(0, 1, 0, 0, 0, "price0");
        request(0, 0, 1, 0, 2, "b2b_coin");
        request(0, 1, 0, 0, 0, "price0_credit");
    endtask

    task automatic test_random();
        for (int i = 0; i < 150; i++) begin
            int p = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 30));
            request($urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 2) != 0,
                    p, $urandom_range(0, 3), "rand");
        end
    endtask

    initial begin
        test_reset();
        test_coins_and_sale();
        test_insufficient();
        test_reject();
        test_priority();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/coffee_credit_ctrl.md
Name: coffee_credit_ctrl

Overview:
Credit and payment sequencer for the coffee machine. Owns the customer credit register and one shared adder instance. The adder is time-multiplexed between coin accumulation (add) and price check/change computation (subtract via cin=1). It sits between the coin/selection front-end and the dispense/change actuators, and issues single-cycle result pulses.

Parameters:
DATA_WIDTH, 8, width of credit, price, change and the shared adder (unsigned money units)

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
coin_valid  input  1  one coin presented this cycle
coin_type  input  2  coin code; value looked up in the package table
sel_valid  input  1  drink selected this cycle
price  input  DATA_WIDTH  price of the selected drink; sampled with sel_valid
cancel  input  1  refund request
busy  output  1  high whenever state != IDLE; requests are ignored while high
credit  output  DATA_WIDTH  current credit register
dispense  output  1  one-cycle pulse: drink paid
change_valid  output  1  one-cycle pulse: change holds the amount to return
change  output  DATA_WIDTH  amount to return; holds its value until the next change_valid
insufficient  output  1  one-cycle pulse: credit < price, no sale
coin_reject  output  1  one-cycle pulse: coin would overflow credit and was not added

Behaviour:
- Reset (synchronous, rst=1 at an edge): state=IDLE, credit=0, change=0, operand=0. All pulses (dispense, change_valid, insufficient, coin_reject) are 0 and busy=0. This applies mid-operation: the in-flight operation is dropped and no pulse is emitted.
- FSM states: IDLE, ADD, CHECK. There are no other states.
- Requests are sampled only in IDLE. Priority is cancel > sel_valid > coin_valid. Lower-priority requests in the same cycle are dropped, not queued.
- Cancel accepted at edge N: change<=credit, credit<=0, change_valid=1 in cycle N+1. This happens even when credit=0 (change=0). No adder use; stay in IDLE.
- Coin accepted at edge N: operand<=COIN_VALUE[coin_type], state->ADD. busy=1 in cycle N+1.
- ADD cycle: adder a=credit, b=operand, cin=0.
  - cout=0: credit<=s.
  - cout=1: credit unchanged, coin_reject=1 in the next cycle.
  - In both cases state->IDLE. New credit is visible in cycle N+2.
- Select accepted at edge N: operand<=price, state->CHECK.
- CHECK cycle: adder a=credit, b=operand, cin=1 (credit - price). The adder's cout=1 means credit >= price (unsigned).
  - cout=1: change<=s, credit<=0, dispense=1 and change_valid=1 in cycle N+2.
  - cout=0: credit unchanged, insufficient=1 in cycle N+2.
  - In both cases state->IDLE.
- Price 0: always sells; change = credit.
- Exact price: sells; change = 0. The adder Z flag is unused by the controller.
- The N and O flags are ignored (unsigned arithmetic). All outputs are registered except busy, which is decoded from the state register.
- Pulses never overlap, except that dispense and change_valid are asserted together.
- Back-to-back requests: a new request can be accepted in the first IDLE cycle after ADD/CHECK, i.e. one request per 2 cycles maximum.

Decomposition:
- Package coffee_pkg holds:
  - state enum (IDLE, ADD, CHECK);
  - coin code typedef (2 bits);
  - COIN_VALUE table: code 0 -> 1, 1 -> 2, 2 -> 5, 3 -> 10.
- Sub-module: the existing adder, instantiated once with DATA_WIDTH passed through. Its cin doubles as the add/subtract select.
- The remainder (FSM, operand mux, credit/change registers) is flat in coffee_credit_ctrl.

Test Plan:
- rst, then coins codes 2,2,1 (5,5,2) each followed by an idle cycle -> credit reads 5, 10, 12, each 2 cycles after its coin_valid; sel price=10 -> dispense=1, change_valid=1, change=2, credit=0, 2 cycles after sel.
- credit=5, sel price=8 -> insufficient pulse for exactly 1 cycle, credit stays 5, dispense=0, change unchanged.
- credit=250, coin code 3 (10) -> coin_reject pulse, credit stays 250; then coin code 0 -> credit 251.
- credit=7, cancel+sel_valid+coin_valid in the same IDLE cycle -> next cycle change_valid=1, change=7, credit=0, busy=0, no dispense, no coin added.
- credit=12, sel price=3, rst=1 during the CHECK cycle -> following cycle credit=0, change=0, busy=0, no dispense/change_valid ever asserted.
- credit=10, sel price=10 -> dispense=1, change=0; requests asserted while busy=1 are ignored (credit unaffected).
